serial_to_8_demux: RTL and testbench

Sequential 1-to-8 demultiplexer and deserializer: the receiving end of the 8-to-1 selection path. A serial bit stream, one bit per accepted beat, is steered into lane `cur_sel` of an 8-lane assembly register; after 8 beats the word is presented as `out_lines[7:0]` with a valid/ready handshake. Lane order matches the mux convention: beat `i` of a word lands on `out_lines[i]`, so a transmitter sweeping `selector_bits` 0→7 is reassembled bit-exact.

---
 rtl/mux_pkg.sv | 7 +
 rtl/serial_to_8_demux_if.sv | 27 ++
 rtl/serial_to_8_demux_lane_sel_counter.sv | 27 ++
 rtl/serial_to_8_demux.sv | 62 ++++++
 tb/tb_serial_to_8_demux.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared lane-count and lane-index types for the 8-lane mux/demux pair
package mux_pkg;
   localparam int N_LANES_DEFAULT = 8;
   localparam int SEL_W_DEFAULT   = $clog2(N_LANES_DEFAULT);

   typedef logic [SEL_W_DEFAULT-1:0] lane_sel_t;
endpackage

// File: rtl/serial_to_8_demux_if.sv
// rtl/serial_to_8_demux_if.sv - serial input beat and assembled-word output handshake bundle
interface serial_to_8_demux_if #(
   parameter int N_LANES = mux_pkg::N_LANES_DEFAULT
);
   localparam int SEL_W = $clog2(N_LANES);

   logic               in_bit;
   logic               in_valid;
   logic               in_ready;
   logic               clear;
   logic [SEL_W-1:0]   cur_sel;
   logic [N_LANES-1:0] out_lines;
   logic               out_valid;
   logic               out_ready;

   // Driver of the serial stream and consumer of assembled words
   modport master (
      output in_bit, in_valid, clear, out_ready,
      input  in_ready, cur_sel, out_lines, out_valid
   );

   // The demultiplexer itself
   modport slave (
      input  in_bit, in_valid, clear, out_ready,
      output in_ready, cur_sel, out_lines, out_valid
   );
endinterface

// File: rtl/serial_to_8_demux_lane_sel_counter.sv
// rtl/serial_to_8_demux_lane_sel_counter.sv - wrapping lane index counter with clear and last flag
module lane_sel_counter #(
   parameter int N_LANES = mux_pkg::N_LANES_DEFAULT
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       inc,
   input  logic                       clr,
   output logic [$clog2(N_LANES)-1:0] count,
   output logic                       last
);
   localparam int SEL_W = $clog2(N_LANES);
   localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_LANES - 1);

   assign last = (count == LAST_IDX);

   // Clear wins over increment; the last lane wraps back to lane 0
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc) begin
         count <= last ? '0 : count + 1'b1;
      end
   end
endmodule

// File: rtl/serial_to_8_demux.sv
// rtl/serial_to_8_demux.sv - serial-to-parallel 1-to-8 demultiplexer with valid/ready word output
module serial_to_8_demux
   import mux_pkg::*;
#(
   parameter int N_LANES = N_LANES_DEFAULT
) (
   input logic               clk,
   input logic               reset,
   serial_to_8_demux_if.slave bus
);
   logic [N_LANES-1:0] asm_q;
   logic [N_LANES-1:0] word_next;
   logic               sel_last;
   logic               accept;
   logic               word_done;
   logic               word_taken;

   // Stall only when the closing beat would overwrite a word nobody has taken
   assign bus.in_ready = !bus.clear && !(sel_last && bus.out_valid && !bus.out_ready);
   assign accept       = bus.in_valid && bus.in_ready;
   assign word_done    = accept && sel_last;
   assign word_taken   = bus.out_valid && bus.out_ready;

   lane_sel_counter #(
      .N_LANES (N_LANES)
   ) u_sel (
      .clk   (clk),
      .reset (reset),
      .inc   (accept),
      .clr   (bus.clear),
      .count (bus.cur_sel),
      .last  (sel_last)
   );

   // Assembly contents with the current beat merged in, used for the word transfer
   always_comb begin
      word_next              = asm_q;
      word_next[bus.cur_sel] = bus.in_bit;
   end

   // Steer each accepted bit into its lane of the assembly register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         asm_q <= '0;
      end else if (accept) begin
         asm_q[bus.cur_sel] <= bus.in_bit;
      end
   end

   // Output holding register: load on word completion, drop valid when taken
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.out_lines <= '0;
         bus.out_valid <= 1'b0;
      end else if (word_done) begin
         bus.out_lines <= word_next;
         bus.out_valid <= 1'b1;
      end else if (word_taken) begin
         bus.out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_serial_to_8_demux.sv
// tb/tb_serial_to_8_demux.sv - randomized self-checking bench for serial_to_8_demux
module tb_serial_to_8_demux;
   import mux_pkg::*;

   logic clk;
   logic reset;

   serial_to_8_demux_if #(.N_LANES(8)) ifc ();

   serial_to_8_demux #(.N_LANES(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int compares;
   int errors;

   // Reference model: beat position, partial word, held word
   int         pos;
   logic [7:0] part;
   logic       mvalid;
   logic [7:0] mword;
   logic [7:0] tx_q[$];
   logic [7:0] rx_q[$];

   // Per-cycle observations from the last step
   logic exp_rdy;
   logic dut_rdy;
   logic acc;

   task automatic model_reset();
      pos    = 0;
      part   = 8'h00;
      mvalid = 1'b0;
      mword  = 8'h00;
   endtask

   // One clock: drive after the falling edge, observe, then advance the model at the rising edge
   task automatic step(input logic vld, input logic b, input logic clr, input logic ordy);
      logic took;
      logic done;
      ifc.in_valid  = vld;
      ifc.in_bit    = b;
      ifc.clear     = clr;
      ifc.out_ready = ordy;
      #1;
      exp_rdy = !clr && !(pos == 7 && mvalid && !ordy);
      dut_rdy = ifc.in_ready;
      acc     = vld && exp_rdy;
      took    = mvalid && ordy;
      done    = 1'b0;
      if (took) rx_q.push_back(ifc.out_lines);
      @(posedge clk);
      if (clr) begin
         pos = 0;
      end else if (acc) begin
         part[pos] = b;
         if (pos == 7) begin
            mword  = part;
            mvalid = 1'b1;
            tx_q.push_back(part);
            pos    = 0;
            done   = 1'b1;
         end else begin
            pos = pos + 1;
         end
      end
      if (took && !done) mvalid = 1'b0;
      @(negedge clk);
   endtask

   task automatic send_word(input logic [7:0] w, input logic ordy);
      for (int i = 0; i < 8; i++) step(1'b1, w[i], 1'b0, ordy);
   endtask

   task automatic test_reset();
      if (ifc.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", ifc.out_valid); end
      compares++;
      if (ifc.out_lines !== 8'h00) begin errors++; $display("FAIL reset_out_lines got %h want 00", ifc.out_lines); end
      compares++;
      if (ifc.cur_sel !== lane_sel_t'(0)) begin errors++; $display("FAIL reset_cur_sel got %0d want 0", ifc.cur_sel); end
      compares++;
      if (ifc.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", ifc.in_ready); end
      compares++;
      // Three beats, then an asynchronous reset between edges
      step(1, 1, 0, 1); step(1, 1, 0, 1); step(1, 0, 0, 1);
      if (ifc.cur_sel !== lane_sel_t'(3)) begin errors++; $display("FAIL pre_reset_cur_sel got %0d want 3", ifc.cur_sel); end
      compares++;
      #2 reset = 1'b1;
      #1;
      if (ifc.cur_sel !== lane_sel_t'(0) || ifc.out_valid !== 1'b0 || ifc.out_lines !== 8'h00 || ifc.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL midword_reset got sel=%0d vld=%b lines=%h rdy=%b want 0/0/00/1",
                  ifc.cur_sel, ifc.out_valid, ifc.out_lines, ifc.in_ready);
      end
      compares++;
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      send_word(8'h96, 1'b0);
      if (ifc.out_valid !== 1'b1 || ifc.out_lines !== 8'h96) begin
         errors++; $display("FAIL post_reset_word got vld=%b lines=%h want 1/96", ifc.out_valid, ifc.out_lines);
      end
      compares++;
      step(0, 0, 0, 1);
   endtask

   task automatic test_basic();
      logic [7:0] w;
      int         hi;
      w  = 8'h4D;
      hi = 0;
      for (int i = 0; i < 8; i++) begin
         step(1'b1, w[i], 1'b0, 1'b1);
         if (ifc.out_valid === 1'b1) hi++;
      end
      if (ifc.out_lines !== 8'h4D) begin errors++; $display("FAIL basic_word got %h want 4D", ifc.out_lines); end
      compares++;
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 1'b0, 1'b1);
         if (ifc.out_valid === 1'b1) hi++;
      end
      if (hi !== 1) begin errors++; $display("FAIL basic_valid_cycles got %0d want 1", hi); end
      compares++;
   endtask

   task automatic test_back_to_back();
      logic [7:0] w;
      int         stall_bad;
      rx_q.delete();
      send_word(8'hA5, 1'b0);
      w = 8'h3C;
      for (int i = 0; i < 7; i++) step(1'b1, w[i], 1'b0, 1'b0);
      stall_bad = 0;
      for (int i = 0; i < 3; i++) begin
         step(1'b1, w[7], 1'b0, 1'b0);
         if (dut_rdy !== 1'b0 || ifc.cur_sel !== lane_sel_t'(7)) stall_bad++;
      end
      if (stall_bad !== 0) begin errors++; $display("FAIL stall_in_ready bad_cycles=%0d want 0", stall_bad); end
      compares++;
      if (ifc.out_lines !== 8'hA5 || ifc.out_valid !== 1'b1) begin
         errors++; $display("FAIL stall_hold got vld=%b lines=%h want 1/A5", ifc.out_valid, ifc.out_lines);
      end
      compares++;
      step(1'b1, w[7], 1'b0, 1'b1);
      if (dut_rdy !== 1'b1) begin errors++; $display("FAIL release_in_ready got %b want 1", dut_rdy); end
      compares++;
      if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) begin errors++; $display("FAIL first_taken got n=%0d want A5", rx_q.size()); end
      compares++;
      if (ifc.out_valid !== 1'b1 || ifc.out_lines !== 8'h3C) begin
         errors++; $display("FAIL second_loaded got vld=%b lines=%h want 1/3C", ifc.out_valid, ifc.out_lines);
      end
      compares++;
      step(0, 0, 0, 1);
   endtask

   task automatic test_clear();
      for (int i = 0; i < 4; i++) step(1, 1, 0, 1);
      step(1'b1, 1'b1, 1'b1, 1'b1);
      if (dut_rdy !== 1'b0) begin errors++; $display("FAIL clear_in_ready got %b want 0", dut_rdy); end
      compares++;
      if (ifc.cur_sel !== lane_sel_t'(0)) begin errors++; $display("FAIL clear_cur_sel got %0d want 0", ifc.cur_sel); end
      compares++;
      send_word(8'h00, 1'b0);
      if (ifc.out_valid !== 1'b1 || ifc.out_lines !== 8'h00) begin
         errors++; $display("FAIL clear_next_word got vld=%b lines=%h want 1/00", ifc.out_valid, ifc.out_lines);
      end
      compares++;
      step(0, 0, 0, 1);
   endtask

   task automatic test_clear_hold();
      rx_q.delete();
      send_word(8'hFF, 1'b0);
      step(1, 0, 1, 0);
      step(1, 1, 0, 0);
      step(1, 0, 1, 0);
      if (ifc.out_valid !== 1'b1 || ifc.out_lines !== 8'hFF) begin
         errors++; $display("FAIL clear_keeps_word got vld=%b lines=%h want 1/FF", ifc.out_valid, ifc.out_lines);
      end
      compares++;
      step(0, 0, 0, 1);
      if (rx_q.size() != 1 || rx_q[0] !== 8'hFF || ifc.out_valid !== 1'b0) begin
         errors++; $display("FAIL clear_delivery got n=%0d vld=%b want 1/0", rx_q.size(), ifc.out_valid);
      end
      compares++;
   endtask

   task automatic test_random();
      int         words;
      int         bit_i;
      int         rdy_bad;
      int         st_bad;
      int         guard;
      logic [7:0] w;
      tx_q.delete();
      rx_q.delete();
      rdy_bad = 0;
      st_bad  = 0;
      words   = 0;
      bit_i   = 0;
      guard   = 0;
      w       = 8'($urandom);
      while (words < 1000 && guard < 60000) begin
         step(($urandom_range(0, 3) != 0), w[bit_i], ($urandom_range(0, 63) == 0),
              ($urandom_range(0, 2) != 0));
         guard++;
         if (dut_rdy !== exp_rdy) rdy_bad++;
         if (ifc.cur_sel !== lane_sel_t'(pos) || ifc.out_valid !== mvalid ||
             (mvalid && ifc.out_lines !== mword)) st_bad++;
         if (ifc.clear) bit_i = 0;
         else if (acc) bit_i++;
         if (bit_i == 8 || ifc.clear) begin
            if (bit_i == 8) words++;
            bit_i = 0;
            w = 8'($urandom);
         end
      end
      for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
      if (guard >= 60000) begin errors++; $display("FAIL random_timeout words=%0d want 1000", words); end
      compares++;
      if (rdy_bad !== 0) begin errors++; $display("FAIL random_in_ready bad_cycles=%0d want 0", rdy_bad); end
      compares++;
      if (st_bad !== 0) begin errors++; $display("FAIL random_state bad_cycles=%0d want 0", st_bad); end
      compares++;
      if (rx_q.size() != tx_q.size()) begin
         errors++; $display("FAIL random_count got %0d words want %0d", rx_q.size(), tx_q.size());
      end
      compares++;
      for (int i = 0; i < tx_q.size() && i < rx_q.size(); i++) begin
         if (rx_q[i] !== tx_q[i]) begin
            errors++; $display("FAIL random_word[%0d] got %h want %h", i, rx_q[i], tx_q[i]);
         end
         compares++;
      end
   endtask

   initial begin
      compares      = 0;
      errors        = 0;
      reset         = 1'b1;
      ifc.in_bit    = 1'b0;
      ifc.in_valid  = 1'b0;
      ifc.clear     = 1'b0;
      ifc.out_ready = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      test_reset();
      test_basic();
      test_back_to_back();
      test_clear();
      test_clear_hold();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errors);
      $finish;
   end
endmodule
